// File: rtl/debug_slave_pkg.sv
// Shared defaults, helpers and the command record for the debug slave command path.
package debug_slave_pkg;

    localparam int unsigned SR_W_DEF = 38;
    localparam int unsigned IR_W_DEF = 2;

    localparam int unsigned CMD_IR_W   = IR_W_DEF;
    localparam int unsigned CMD_DATA_W = SR_W_DEF;

    // Command record at default widths; the top builds the same shape at its own widths.
    typedef struct packed {
        logic [CMD_IR_W-1:0]   ir;
        logic [CMD_DATA_W-1:0] data;
    } dbg_cmd_t;

    // Ceiling log2, never less than 1, so that counters are always at least one bit wide.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// Single-clock first-word-fall-through command FIFO with occupancy output.
module debug_slave_cmd_fifo
    import debug_slave_pkg::*;
#(
    parameter type         cmd_t = dbg_cmd_t,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  cmd_t        wdata,
    input  logic        pop,
    output cmd_t        rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    cmd_t        mem_q [DEPTH];
    cmd_t        last_q;
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);
    // When empty, keep presenting the entry that was popped last.
    assign rdata   = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    // Pointer and hold-register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// System-clock side of the JTAG debug slave: toggle synchronisation, IR latch,
// command queueing and per-IR action pulse decode.
module debug_slave_cmd_sync
    import debug_slave_pkg::*;
#(
    parameter int unsigned SR_W        = SR_W_DEF,
    parameter int unsigned IR_W        = IR_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned NOACT_BIT   = 35
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uir_tgl,
    input  logic                     udr_tgl,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     ovf_clr,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [SR_W-1:0]          jdo,
    output logic                     ir_change,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [(2**IR_W)-1:0]     take_no_action,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned NCH = 2 ** IR_W;
    localparam int unsigned SW  = clog2_min1(SYNC_STAGES + 2);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } cmd_t;

    logic [1:0]      tgl;
    logic [1:0]      edge_raw;
    logic [SW-1:0]   settle_q;
    logic            settled;
    logic            uir_edge_q;
    logic            udr_edge_q;
    logic [IR_W-1:0] ir_latched_q;
    logic            ir_change_q;
    logic [NCH-1:0]  take_action_q;
    logic [NCH-1:0]  take_no_action_q;
    logic            overflow_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop_fire;
    logic            drop;
    cmd_t            wcmd;
    cmd_t            head;

    assign tgl = {udr_tgl, uir_tgl};

    // Channel 0 is update-IR, channel 1 is update-DR.
    for (genvar c = 0; c < 2; c++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;

        // Synchroniser chain plus one delayed copy of its output for edge detection.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], tgl[c]};
                prev_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign edge_raw[c] = sync_q[SYNC_STAGES-1] ^ prev_q;
    end

    // After reset the chains refill with whatever level the toggles sit at; edges are
    // masked until that level has propagated, so a toggle in flight during reset is lost.
    assign settled = (settle_q == SW'(SYNC_STAGES + 1));

    // Settle counter and registered edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_q   <= '0;
            uir_edge_q <= 1'b0;
            udr_edge_q <= 1'b0;
        end else begin
            if (!settled) begin
                settle_q <= settle_q + 1'b1;
            end
            uir_edge_q <= settled & edge_raw[0];
            udr_edge_q <= settled & edge_raw[1];
        end
    end

    // Build the command to queue; a same-cycle IR update takes the fresh IR.
    always_comb begin
        wcmd      = '0;
        wcmd.ir   = uir_edge_q ? ir_in : ir_latched_q;
        wcmd.data = sr;
    end

    debug_slave_cmd_fifo #(
        .cmd_t (cmd_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (udr_edge_q),
        .wdata (wcmd),
        .pop   (cmd_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign cmd_valid = ~fifo_empty;
    assign cmd_ir    = head.ir;
    assign jdo       = head.data;
    assign pop_fire  = cmd_valid & cmd_ready;
    assign drop      = udr_edge_q & fifo_full & ~pop_fire;

    // IR latch, IR-change pulse, action decode on pop and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_latched_q     <= '0;
            ir_change_q      <= 1'b0;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            if (uir_edge_q) begin
                ir_latched_q <= ir_in;
            end
            ir_change_q      <= uir_edge_q;
            take_action_q    <= '0;
            take_no_action_q <= '0;
            if (pop_fire) begin
                if (head.data[NOACT_BIT]) begin
                    take_no_action_q <= NCH'(1) << head.ir;
                end else begin
                    take_action_q <= NCH'(1) << head.ir;
                end
            end
            overflow_q <= drop | (overflow_q & ~ovf_clr);
        end
    end

    assign ir_change      = ir_change_q;
    assign take_action    = take_action_q;
    assign take_no_action = take_no_action_q;
    assign overflow       = overflow_q;

endmodule

// File: doc/debug_slave_cmd_sync.md
Name: debug_slave_cmd_sync

Overview:
- System-clock half of the JTAG debug slave, generalised in IR width, shift-register width and synchroniser depth.
- Receives update-IR and update-DR toggles from the TCK-domain shift logic, synchronises and edge-detects them, and latches the IR.
- Queues each captured DR snapshot in a small command FIFO, then pops commands under a valid/ready handshake.
- On each pop, emits one-cycle take_action / take_no_action pulses, one channel per IR code. Adds queuing and overflow reporting so back-to-back JTAG updates are never silently merged.

Parameters:
- SR_W, 38, width of TCK-side shift register snapshot and of jdo.
- IR_W, 2, virtual IR width; number of action channels = 2**IR_W.
- SYNC_STAGES, 2, flip-flops in each toggle synchroniser (min 2).
- DEPTH, 4, command FIFO entries (power of 2, min 2).
- NOACT_BIT, 35, jdo bit that selects take_no_action (1) vs take_action (0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uir_tgl  in  1  toggles once per TCK update-IR; asynchronous to clk
- udr_tgl  in  1  toggles once per TCK update-DR; asynchronous to clk
- ir_in  in  IR_W  TCK-side IR; stable ≥ SYNC_STAGES+2 clk after uir_tgl edge
- sr  in  SR_W  TCK-side DR snapshot; stable ≥ SYNC_STAGES+2 clk after udr_tgl edge
- cmd_ready  in  1  consumer accepts head command
- ovf_clr  in  1  clears sticky overflow
- cmd_valid  out  1  FIFO non-empty
- cmd_ir  out  IR_W  IR of head command
- jdo  out  SR_W  DR data of head command
- ir_change  out  1  one-cycle pulse on each synchronised update-IR
- take_action  out  2**IR_W  one-hot pulse on pop, jdo[NOACT_BIT]==0
- take_no_action  out  2**IR_W  one-hot pulse on pop, jdo[NOACT_BIT]==1
- overflow  out  1  sticky: an update-DR was dropped because FIFO full
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (any cycle, including mid-operation) has the following effects:
  - Sync chains, edge-detect registers, FIFO pointers and ir_latched go to 0. Pending commands are discarded.
  - All outputs go to 0: cmd_valid, cmd_ir, jdo, ir_change, take_action, take_no_action, overflow, level.
  - A toggle in flight during reset is absorbed; no edge is generated after reset release.
- Edge detection: each toggle passes through SYNC_STAGES flops. The edge is the XOR of the last stage with a prev register (1 extra flop).
- uir edge: ir_latched <= ir_in; ir_change pulses 1 cycle (registered).
- udr edge: push {ir_sel, sr} into the FIFO.
  - ir_sel = ir_in if a uir edge occurs in the same cycle, else ir_latched.
- Latency: a toggle first sampled at edge k gives the internal edge at k+SYNC_STAGES. The FIFO write completes at k+SYNC_STAGES+1, so with an empty FIFO cmd_valid=1 from k+SYNC_STAGES+1.
- FIFO is first-word-fall-through: cmd_ir and jdo show the head entry whenever cmd_valid=1, and hold their last value when empty.
- Pop on cmd_valid & cmd_ready. In the same cycle the pop registers a 1-cycle pulse, visible on the next cycle:
  - take_action[cmd_ir] if jdo[NOACT_BIT]==0;
  - take_no_action[cmd_ir] otherwise.
- At most one bit across both pulse vectors is high in any cycle.
- Simultaneous push and pop:
  - Always allowed when not full.
  - When full, the pop frees a slot and the push is accepted in the same cycle; no overflow.
- Full without pop: the push is dropped and overflow <= 1. Existing entries are unchanged.
- ovf_clr clears overflow. If a drop occurs in the same cycle, set wins: overflow stays 1.
- Pointers wrap modulo DEPTH. level = wr_count − rd_count, range 0..DEPTH.
- ir_in and sr are sampled only on the synchronised edge cycle and are never registered through the synchroniser.

Decomposition:
- Package debug_slave_pkg holds:
  - defaults SR_W_DEF=38, IR_W_DEF=2;
  - function clog2_min1;
  - typedef dbg_cmd_t = struct {ir, data}, parametrised via localparam widths.
- Sub-module debug_slave_cmd_fifo: single-clock FWFT FIFO of dbg_cmd_t, DEPTH entries, with full, empty and level.
- Synchroniser and edge-detect stay inline (generate loop).

Test Plan:
- Reset mid-stream: push 2 commands, assert reset 1 cycle → next cycle cmd_valid=0, level=0, overflow=0; no take_* pulse ever appears for the discarded commands.
- Latency and decode:
  - Stimulus: ir_in=2, toggle uir, then sr=38'h0_0000_00AB with bit35=0, toggle udr at edge k, cmd_ready=1.
  - Required: cmd_valid at k+3, cmd_ir=2, jdo=0xAB; take_action=4'b0100 for exactly 1 cycle at k+4.
- No-action path: same stimulus with sr bit35=1 → take_no_action=4'b0100, take_action stays 0.
- Overflow (DEPTH=4, cmd_ready=0):
  - Stimulus: 5 udr toggles with sr=1..5.
  - Required: level=4, overflow=1, pops return 1,2,3,4.
  - Then ovf_clr → overflow=0.
- Full with simultaneous push and pop: FIFO full, cmd_ready=1 in the cycle a 5th edge arrives → level stays 4, overflow=0, data order preserved.
- Same-cycle uir and udr: ir_latched=1, ir_in=3, both toggles flipped together → queued cmd_ir=3, ir_change pulses once.
